mem_debug_ctrl: RTL
===================

Name: mem_debug_ctrl

Overview:
- Parametrised memory-dump and debug arbiter between RISC_PROCESSOR and the board RAM.
- Generalises the fixed 8-bit dump counter and address mux into one block:
  - parametrised address and data widths;
  - programmable start/end dump window;
  - step mode and auto-scan mode;
  - end-of-window hold or wrap;
  - CPU write suppression and a stall flag while dumping.
- Feeds the RAM address/write port and the Display_Controller address digits.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- SCAN_DIV, 25000000, clk cycles per auto-scan advance; must be >= 2.
- WRAP, 0, at end of window: 1 = return to start_addr; 0 = hold and flag done.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset asserted when low, sampled on rising clk.
- dump_mem  in  1  level from the board switch; 1 = dump mode requested.
- step_mem  in  1  debounced step button, level; the block edge-detects it internally.
- auto_en  in  1  1 = auto-scan advance; 0 = step-button advance.
- start_addr  in  ADDR_W  first dump address, sampled on dump entry.
- end_addr  in  ADDR_W  last dump address, sampled live.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_we  in  1  CPU write enable (mw_en).
- cpu_din  in  DATA_W  CPU write data.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_din  out  DATA_W  RAM write data; always equals cpu_din.
- disp_addr  out  16  mem_addr zero-extended to 16 bits, for the display.
- dump_active  out  1  high in DUMP or HOLD.
- dump_done  out  1  high in HOLD only.
- cpu_stall  out  1  equals dump_active; upstream uses it to freeze the CPU step clock.

Behaviour:
- Registers:
  - state ∈ {RUN, DUMP, HOLD};
  - ptr [ADDR_W];
  - step_q;
  - tick counter, width $clog2(SCAN_DIV).
- Reset (reset=0 at a rising edge):
  - state=RUN, ptr=0, step_q=0, tick counter=0.
  - mem_we is forced 0 combinationally while reset=0.
  - All other outputs follow their RUN-state values: mem_addr=cpu_addr; dump_active=dump_done=cpu_stall=0.
- step_rise = step_mem & ~step_q.
  - step_q <= step_mem every cycle.
  - One press produces exactly one advance regardless of hold length.
- tick:
  - Asserted for one cycle when the counter equals SCAN_DIV-1; the counter then returns to 0.
  - The counter runs only in DUMP with auto_en=1, and is held at 0 otherwise.
- adv:
  - auto_en=1: adv = tick; step_rise is ignored.
  - auto_en=0: adv = step_rise.
- RUN:
  - mem_addr=cpu_addr, mem_we=cpu_we.
  - If dump_mem=1: next state DUMP, ptr <= start_addr, tick counter <= 0.
  - The first dump address is presented 1 cycle after dump_mem is sampled high.
- DUMP:
  - mem_addr=ptr, mem_we=0 (CPU writes are dropped, not queued).
  - Priority when events coincide, highest first:
    - dump_mem=0: next state RUN, ptr unchanged; any same-cycle adv is discarded.
    - adv with ptr==end_addr:
      - WRAP=1: ptr <= start_addr, stay in DUMP.
      - WRAP=0: next state HOLD, ptr unchanged.
    - adv otherwise: ptr <= ptr+1 modulo 2^ADDR_W.
  - start_addr > end_addr is legal: ptr counts up through 2^ADDR_W-1, wraps to 0, and continues to end_addr.
- HOLD:
  - mem_addr=ptr (= end_addr), mem_we=0, dump_done=1.
  - All adv ignored.
  - dump_mem=0: next state RUN.
- Re-entry: every RUN→DUMP transition reloads ptr from start_addr.
- Mid-dump changes:
  - start_addr changes take effect only on the next entry or wrap.
  - end_addr is compared live.
  - Toggling auto_en clears the tick counter.
- Reset mid-dump: returns to RUN on that edge; the CPU regains the address bus the same cycle.
- Latency:
  - The RAM is synchronous-read, so read data for mem_addr appears 1 cycle later.
  - The display shows disp_addr from the same cycle as mem_addr and the RAM data 1 cycle later; no extra alignment is done in this block.

Decomposition:
- Shared package / header:
  - state encoding constants ST_RUN=2'd0, ST_DUMP=2'd1, ST_HOLD=2'd2;
  - default widths ADDR_W_DEF=8, DATA_W_DEF=16.
- One natural sub-module: scan_tick_gen.
  - Parameter: SCAN_DIV.
  - Ports: clk, reset, en → tick.
  - Reused later for display-refresh timing.
- Edge detect and the FSM stay inline.

Test Plan (bench SCAN_DIV=4, ADDR_W=8):
- Passthrough: reset=0 then 1; cpu_addr=8'h3C, cpu_we=1, dump_mem=0 → mem_addr=8'h3C, mem_we=1; mem_we=0 during reset cycles; dump_active=0.
- Step dump, WRAP=0: start=8'h10, end=8'h12, auto_en=0, dump_mem=1, three step presses held 5 cycles each → mem_addr 10,11,12, then HOLD with dump_done=1; a fourth press leaves mem_addr=12; cpu_we=1 throughout gives mem_we=0.
- Auto scan, WRAP=1: start=8'hFE, end=8'h01, auto_en=1 → mem_addr FE,FF,00,01,FE, advancing every 4 cycles; dump_done stays 0.
- Exit priority: in DUMP at ptr=8'h20, drop dump_mem in the same cycle as step_rise → next cycle state RUN, mem_addr=cpu_addr; re-entry restarts at start_addr.
- Reset mid-dump: in DUMP at ptr=8'h45, reset=0 for 1 cycle → state RUN, ptr=0, cpu_stall=0 next cycle.
- Mode toggle: auto_en 1→0 at counter=2, then 0→1 → next advance comes 4 cycles after re-enable, not 2.

Source files
------------

// File: rtl/mem_debug_ctrl_pkg.sv
// Shared definitions for the memory-dump / debug arbiter: state encoding and
// default bus widths.
package mem_debug_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DUMP = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/mem_debug_ctrl_scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV enabled cycles,
// cleared whenever en drops.
module scan_tick_gen #(
    parameter int SCAN_DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_debug_ctrl.sv
// Arbitrates the RAM address/write port between the CPU and a windowed
// memory dump advanced by the step button or an auto-scan tick.
module mem_debug_ctrl
    import mem_debug_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int          SCAN_DIV = 25000000,
    parameter int unsigned WRAP     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_mem,
    input  logic              step_mem,
    input  logic              auto_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    output logic [15:0]       disp_addr,
    output logic              dump_active,
    output logic              dump_done,
    output logic              cpu_stall
);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              step_q;

    logic step_rise;
    logic tick_en;
    logic tick;
    logic adv;
    logic dumping;

    assign step_rise = step_mem & ~step_q;
    assign tick_en   = (state_q == ST_DUMP) & auto_en;
    assign adv       = auto_en ? tick : step_rise;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            step_q <= step_mem;
            case (state_q)
                ST_RUN: begin
                    if (dump_mem) begin
                        state_q <= ST_DUMP;
                        ptr_q   <= start_addr;
                    end
                end
                ST_DUMP: begin
                    // Leaving dump mode outranks any advance in the same cycle.
                    if (!dump_mem) begin
                        state_q <= ST_RUN;
                    end else if (adv) begin
                        if (ptr_q == end_addr) begin
                            if (WRAP != 0) begin
                                ptr_q <= start_addr;
                            end else begin
                                state_q <= ST_HOLD;
                            end
                        end else begin
                            ptr_q <= ptr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!dump_mem) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // While reset is low the CPU owns the bus and writes are blocked.
    assign dumping     = reset & (state_q != ST_RUN);
    assign mem_addr    = dumping ? ptr_q : cpu_addr;
    assign mem_we      = reset & ~dumping & cpu_we;
    assign mem_din     = cpu_din;
    assign disp_addr   = 16'(mem_addr);
    assign dump_active = dumping;
    assign dump_done   = reset & (state_q == ST_HOLD);
    assign cpu_stall   = dumping;

endmodule
